// File: rtl/row_request_generator.sv
// ---------------------------------------------------------------------------
// row_request_generator
//
// Producer stage that sits in front of the relational-cache request queue.
// A start pulse walks a table row by row and, inside each row, column by
// column. For every (row, column) pair it pushes the absolute address of
// that column field: row_ptr + column_offsets[col]. Pushes are withheld
// while the queue reports full. A one-cycle done pulse follows the final
// accepted address.
//
// Ports
//   clock, reset     system clock, synchronous active-high reset
//   start            single-cycle start pulse, honoured only in IDLE
//   base_address     address of row 0
//   row_size         byte stride between consecutive rows
//   row_count        number of rows to walk
//   column_count     columns per row (clamped to MAX_COLUMNS)
//   column_offsets   packed per-column byte offsets, column c in
//                    bits [c*REGISTER_SIZE +: REGISTER_SIZE]
//   queue_full       downstream queue full flag
//   push_value       address presented to the queue
//   push_valid       queue write strobe (every asserted cycle is a push)
//   last_request     marks the final address of the walk
//   busy             high while addresses are being generated
//   done             one-cycle completion pulse
//   issued_count     addresses pushed since the last accepted start
// ---------------------------------------------------------------------------
module row_request_generator #(
    parameter int ADDR_SIZE     = 32,
    parameter int REGISTER_SIZE = 32,
    parameter int MAX_COLUMNS   = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [ADDR_SIZE-1:0]                 base_address,
    input  logic [ADDR_SIZE-1:0]                 row_size,
    input  logic [REGISTER_SIZE-1:0]             row_count,
    input  logic [$clog2(MAX_COLUMNS):0]         column_count,
    input  logic [MAX_COLUMNS*REGISTER_SIZE-1:0] column_offsets,
    input  logic                                 queue_full,
    output logic [ADDR_SIZE-1:0]                 push_value,
    output logic                                 push_valid,
    output logic                                 last_request,
    output logic                                 busy,
    output logic                                 done,
    output logic [REGISTER_SIZE-1:0]             issued_count
);

    localparam int CW = $clog2(MAX_COLUMNS) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   state_q;

    // Configuration captured at start so later input changes are ignored.
    logic [ADDR_SIZE-1:0]     row_size_q;
    logic [REGISTER_SIZE-1:0] row_count_q;
    logic [CW-1:0]            colcnt_q;
    logic [REGISTER_SIZE-1:0] offsets_q [MAX_COLUMNS];

    // Walk position.
    logic [ADDR_SIZE-1:0]     row_ptr_q;
    logic [REGISTER_SIZE-1:0] row_idx_q;
    logic [CW-1:0]            col_idx_q;
    logic [REGISTER_SIZE-1:0] issued_count_q;

    // Unpacked view of the offset bus.
    logic [REGISTER_SIZE-1:0] offsets_w [MAX_COLUMNS];

    generate
        for (genvar gi = 0; gi < MAX_COLUMNS; gi++) begin : g_offsets
            assign offsets_w[gi] = column_offsets[gi*REGISTER_SIZE +: REGISTER_SIZE];
        end
    endgenerate

    logic [CW-1:0]            colcnt_eff;
    logic                     in_run;
    logic                     push;
    logic                     last_col;
    logic                     last_row;
    logic [REGISTER_SIZE-1:0] sel_offset;
    logic [CW-1:0]            col_idx_d;
    logic [REGISTER_SIZE-1:0] row_idx_d;
    logic [ADDR_SIZE-1:0]     row_ptr_d;

    assign colcnt_eff = (column_count > CW'(MAX_COLUMNS)) ? CW'(MAX_COLUMNS) : column_count;

    // Outputs are forced quiet while reset is asserted, even mid-walk.
    assign in_run   = (state_q == S_RUN) && !reset;
    assign push     = in_run && !queue_full;
    assign last_col = (col_idx_q == colcnt_q - CW'(1));
    assign last_row = (row_idx_q == row_count_q - REGISTER_SIZE'(1));

    // Offset select written as an explicit compare mux so the column index
    // can stay wider than a bare array index.
    always_comb begin
        sel_offset = '0;
        for (int c = 0; c < MAX_COLUMNS; c++) begin
            if (col_idx_q == CW'(c)) begin
                sel_offset = offsets_q[c];
            end
        end
    end

    // Position after a push: next column, or wrap to column 0 of next row.
    // The row pointer advances by accumulation, so it wraps naturally.
    always_comb begin
        col_idx_d = col_idx_q + CW'(1);
        row_idx_d = row_idx_q;
        row_ptr_d = row_ptr_q;
        if (last_col) begin
            col_idx_d = '0;
            row_idx_d = row_idx_q + REGISTER_SIZE'(1);
            row_ptr_d = row_ptr_q + row_size_q;
        end
    end

    assign push_valid   = push;
    assign push_value   = in_run ? (row_ptr_q + ADDR_SIZE'(sel_offset)) : '0;
    assign last_request = push && last_row && last_col;
    assign busy         = (state_q == S_RUN) && !reset;
    assign done         = (state_q == S_DONE) && !reset;
    assign issued_count = issued_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            row_size_q     <= '0;
            row_count_q    <= '0;
            colcnt_q       <= '0;
            row_ptr_q      <= '0;
            row_idx_q      <= '0;
            col_idx_q      <= '0;
            issued_count_q <= '0;
            for (int c = 0; c < MAX_COLUMNS; c++) begin
                offsets_q[c] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        row_size_q     <= row_size;
                        row_count_q    <= row_count;
                        colcnt_q       <= colcnt_eff;
                        row_ptr_q      <= base_address;
                        row_idx_q      <= '0;
                        col_idx_q      <= '0;
                        issued_count_q <= '0;
                        for (int c = 0; c < MAX_COLUMNS; c++) begin
                            offsets_q[c] <= offsets_w[c];
                        end
                        // An empty walk still produces its done pulse.
                        if (row_count == '0 || colcnt_eff == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (push) begin
                        col_idx_q      <= col_idx_d;
                        row_idx_q      <= row_idx_d;
                        row_ptr_q      <= row_ptr_d;
                        issued_count_q <= issued_count_q + REGISTER_SIZE'(1);
                        if (last_row && last_col) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_row_request_generator.sv
// ---------------------------------------------------------------------------
// tb_row_request_generator
//
// Scoreboard bench. The driver computes every expected address of a walk
// from base + row*row_size + offset[col] and queues it before pulsing
// start; a negedge monitor pops and compares on each push_valid and checks
// the done pulse against the expected push count.
// ---------------------------------------------------------------------------
module tb_row_request_generator;

    localparam int AW = 32;
    localparam int RW = 32;
    localparam int MC = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic          last;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              start;
    logic [AW-1:0]     base_address;
    logic [AW-1:0]     row_size;
    logic [RW-1:0]     row_count;
    logic [2:0]        column_count;
    logic [MC*RW-1:0]  column_offsets;
    logic              queue_full;
    logic [AW-1:0]     push_value;
    logic              push_valid;
    logic              last_request;
    logic              busy;
    logic              done;
    logic [RW-1:0]     issued_count;

    exp_t sb[$];
    int   n_cmp       = 0;
    int   n_bad       = 0;
    int   cyc         = 0;
    int   pushes_seen = 0;
    int   done_seen   = 0;
    int   done_cyc    = 0;
    int   exp_issued  = 0;
    logic last_prev   = 1'b0;

    row_request_generator #(
        .ADDR_SIZE     (AW),
        .REGISTER_SIZE (RW),
        .MAX_COLUMNS   (MC)
    ) dut (
        .clock          (clk),
        .reset          (reset),
        .start          (start),
        .base_address   (base_address),
        .row_size       (row_size),
        .row_count      (row_count),
        .column_count   (column_count),
        .column_offsets (column_offsets),
        .queue_full     (queue_full),
        .push_value     (push_value),
        .push_valid     (push_valid),
        .last_request   (last_request),
        .busy           (busy),
        .done           (done),
        .issued_count   (issued_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: one line per push and per done pulse.
    always @(negedge clk) begin
        cyc++;
        if (push_valid) begin
            check("no_push_while_full", queue_full, 0);
            if (sb.size() == 0) begin
                check("unexpected_push", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("push_value", push_value, e.addr);
                check("last_request", last_request, e.last);
            end
            pushes_seen++;
            $display("push: addr=0x%08h last=%0b", push_value, last_request);
        end else begin
            check("last_without_valid", last_request, 0);
        end
        if (done) begin
            done_seen++;
            done_cyc = cyc;
            $display("done: issued=%0d", issued_count);
            check("busy_in_done", busy, 0);
            check("issued_count_at_done", issued_count, exp_issued);
            check("pending_at_done", sb.size(), 0);
            if (exp_issued > 0) check("done_follows_last", last_prev, 1);
        end
        last_prev = push_valid & last_request;
    end

    // Queue the reference address list for one walk; returns its length.
    task automatic build_expect(input logic [AW-1:0] base, input logic [AW-1:0] rsize,
                                input logic [RW-1:0] rows, input logic [2:0] ccount,
                                input logic [MC*RW-1:0] offs, output int n);
        int   colc;
        exp_t e;
        colc = (ccount > 3'd4) ? 4 : int'(ccount);
        n = 0;
        if (rows != 0 && colc != 0) begin
            for (int r = 0; r < int'(rows); r++) begin
                for (int c = 0; c < colc; c++) begin
                    e.addr = base + AW'(r) * rsize + offs[c*RW +: RW];
                    e.last = (r == int'(rows) - 1) && (c == colc - 1);
                    sb.push_back(e);
                    n++;
                end
            end
        end
    endtask

    // fmode: 0 never full, 1 random full, 2 full for 3 cycles after 2nd push.
    task automatic run_walk(input logic [AW-1:0] base, input logic [AW-1:0] rsize,
                            input logic [RW-1:0] rows, input logic [2:0] ccount,
                            input logic [MC*RW-1:0] offs, input int fmode,
                            input bit restart_pulse);
        int n;
        int s_cyc;
        int d0;
        int k;
        int fullcnt;
        build_expect(base, rsize, rows, ccount, offs, n);
        exp_issued = n;
        @(posedge clk); #1;
        base_address   = base;
        row_size       = rsize;
        row_count      = rows;
        column_count   = ccount;
        column_offsets = offs;
        queue_full     = 1'b0;
        start          = 1'b1;
        s_cyc          = cyc + 1;
        d0             = done_seen;
        pushes_seen    = 0;
        @(posedge clk); #1;
        start = 1'b0;
        // Configuration is latched; scramble the inputs.
        base_address   = $urandom;
        row_size       = $urandom;
        row_count      = RW'($urandom_range(0, 9));
        column_count   = 3'($urandom_range(0, 7));
        column_offsets = {$urandom, $urandom, $urandom, $urandom};
        k = 0;
        fullcnt = 0;
        while (done_seen == d0 && k < 3000) begin
            case (fmode)
                1: queue_full = ($urandom_range(0, 3) == 0);
                2: begin
                    if (pushes_seen >= 2 && fullcnt < 3) begin
                        queue_full = 1'b1;
                        fullcnt++;
                    end else begin
                        queue_full = 1'b0;
                    end
                end
                default: queue_full = 1'b0;
            endcase
            start = restart_pulse && (k == 1);
            @(posedge clk); #1;
            k++;
        end
        start      = 1'b0;
        queue_full = 1'b0;
        if (done_seen == d0) begin
            check("walk_timeout", 0, 1);
        end else if (fmode == 0) begin
            check("done_latency", done_cyc - s_cyc, (n == 0) ? 1 : n + 1);
        end
        if (fmode == 2) check("backpressure_cycles", fullcnt, 3);
        @(negedge clk);
        check("done_single_cycle", done, 0);
        check("idle_after_done", busy, 0);
        check("issued_count_hold", issued_count, n);
        sb.delete();
    endtask

    initial begin
        logic [MC*RW-1:0] offs_basic;
        int n;
        int k;
        offs_basic     = {32'h0, 32'h10, 32'h8, 32'h0};
        reset          = 1'b1;
        start          = 1'b0;
        base_address   = '0;
        row_size       = '0;
        row_count      = '0;
        column_count   = '0;
        column_offsets = '0;
        queue_full     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_push_valid", push_valid, 0);
        check("reset_push_value", push_value, 0);
        check("reset_last", last_request, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_issued", issued_count, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic walk, then the same walk with backpressure.
        run_walk(32'h1000, 32'h40, 2, 3'd3, offs_basic, 0, 1'b0);
        run_walk(32'h1000, 32'h40, 2, 3'd3, offs_basic, 2, 1'b0);

        // Degenerate configurations.
        run_walk(32'h1000, 32'h40, 0, 3'd3, offs_basic, 0, 1'b0);
        run_walk(32'h1000, 32'h40, 2, 3'd0, offs_basic, 0, 1'b0);

        // Clamp to MAX_COLUMNS with a second start while busy.
        run_walk(32'h2000, 32'h100, 1, 3'd7, {32'h30, 32'h20, 32'h10, 32'h4}, 0, 1'b1);

        // Reset after the second push of a 6-address walk.
        build_expect(32'h1000, 32'h40, 2, 3'd3, offs_basic, n);
        exp_issued = n;
        @(posedge clk); #1;
        base_address   = 32'h1000;
        row_size       = 32'h40;
        row_count      = 2;
        column_count   = 3'd3;
        column_offsets = offs_basic;
        start          = 1'b1;
        pushes_seen    = 0;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (pushes_seen < 2 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("reset_walk_progress", pushes_seen >= 2, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        check("post_reset_push_valid", push_valid, 0);
        check("post_reset_busy", busy, 0);
        check("post_reset_issued", issued_count, 0);
        run_walk(32'h1000, 32'h40, 2, 3'd3, offs_basic, 0, 1'b0);

        // Address wrap.
        run_walk(32'hFFFF_FFF0, 32'h20, 2, 3'd1, {32'h0, 32'h0, 32'h0, 32'h8}, 0, 1'b0);

        // Randomized walks.
        for (int t = 0; t < 40; t++) begin
            logic [RW-1:0] rows;
            logic [2:0]    cc;
            int            colc;
            bit            rs;
            rows = RW'($urandom_range(0, 5));
            cc   = 3'($urandom_range(0, 7));
            colc = (cc > 3'd4) ? 4 : int'(cc);
            rs   = (int'(rows) * colc >= 4) && ($urandom_range(0, 1) == 1);
            run_walk($urandom, $urandom, rows, cc,
                     {$urandom, $urandom, $urandom, $urandom},
                     int'($urandom_range(0, 1)), rs);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
